// File: rtl/input_debouncer.sv
// Per-bit input debouncer with registered level and one-cycle pressed/released pulses.
// Optional auto-repeat of pressed while held high: define DEBOUNCE_AUTOREPEAT_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   LOW     | debounced level 0, input agrees
//   RISING  | level 0, counting consecutive 1 samples toward acceptance
//   HIGH    | debounced level 1 (counter tracks auto-repeat when enabled)
//   FALLING | level 1, counting consecutive 0 samples toward acceptance
module input_debouncer #(
  parameter int SIZE          = 1,
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] in,
  output logic [SIZE-1:0] level,
  output logic [SIZE-1:0] pressed,
  output logic [SIZE-1:0] released
);

  localparam int MAX_CYCLES = (STABLE_CYCLES > REPEAT_CYCLES) ? STABLE_CYCLES : REPEAT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {LOW, RISING, HIGH, FALLING} state_t;

  for (genvar g = 0; g < SIZE; g++) begin : g_bit
    state_t          state;
    logic [CW-1:0]   cnt;
    logic            level_r;
    logic            pressed_r;
    logic            released_r;

    always_ff @(posedge clk) begin
      if (reset) begin
        state      <= LOW;
        cnt        <= '0;
        level_r    <= 1'b0;
        pressed_r  <= 1'b0;
        released_r <= 1'b0;
      end else begin
        pressed_r  <= 1'b0;
        released_r <= 1'b0;
        case (state)
          LOW: begin
            if (in[g]) begin
              state <= RISING;
              cnt   <= CW'(1);
            end
          end
          RISING: begin
            if (!in[g]) begin
              state <= LOW;
              cnt   <= '0;
            end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
              state     <= HIGH;
              cnt       <= '0;
              level_r   <= 1'b1;
              pressed_r <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          HIGH: begin
            if (!in[g]) begin
              state <= FALLING;
              cnt   <= CW'(1);
            end else begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
              // counter measures hold time since entry or the last repeat pulse
              if (cnt == CW'(REPEAT_CYCLES - 1)) begin
                cnt       <= '0;
                pressed_r <= 1'b1;
              end else begin
                cnt <= cnt + CW'(1);
              end
`else
              cnt <= '0;
`endif
            end
          end
          FALLING: begin
            if (in[g]) begin
              state <= HIGH;
              cnt   <= '0;
            end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
              state      <= LOW;
              cnt        <= '0;
              level_r    <= 1'b0;
              released_r <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= LOW;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign level[g]    = level_r;
    assign pressed[g]  = pressed_r;
    assign released[g] = released_r;
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios plus random bouncing input,
// checked every cycle against a run-length reference model.
module tb_input_debouncer;

  localparam int SIZE = 2;
  localparam int STAB = 4;
  localparam int REP  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [SIZE-1:0] in;
  logic [SIZE-1:0] level;
  logic [SIZE-1:0] pressed;
  logic [SIZE-1:0] released;

  input_debouncer #(
    .SIZE(SIZE), .STABLE_CYCLES(STAB), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .reset(reset), .in(in),
    .level(level), .pressed(pressed), .released(released)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference: level flips after STAB consecutive samples disagreeing with it.
  logic [SIZE-1:0] m_level, m_pr, m_rl;
  int              m_run [SIZE];
  int              m_rep [SIZE];

  task automatic model_update(input logic r, input logic [SIZE-1:0] x);
    m_pr = '0;
    m_rl = '0;
    if (r) begin
      m_level = '0;
      for (int b = 0; b < SIZE; b++) begin
        m_run[b] = 0;
        m_rep[b] = 0;
      end
    end else begin
      for (int b = 0; b < SIZE; b++) begin
        if (x[b] != m_level[b]) begin
          m_run[b]++;
          m_rep[b] = 0;
          if (m_run[b] == STAB) begin
            m_level[b] = x[b];
            m_run[b]   = 0;
            if (x[b]) m_pr[b] = 1'b1;
            else      m_rl[b] = 1'b1;
          end
        end else begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
          if (m_level[b] && m_run[b] == 0) begin
            m_rep[b]++;
            if (m_rep[b] == REP) begin
              m_pr[b]  = 1'b1;
              m_rep[b] = 0;
            end
          end
`endif
          m_run[b] = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
  endtask

  task automatic step(input logic r, input logic [SIZE-1:0] v);
    reset = r;
    in    = v;
    @(posedge clk);
    model_update(r, v);
    #1;
    check("level", level, m_level);
    check("pressed", pressed, m_pr);
    check("released", released, m_rl);
    total++;
    assert ((pressed & released) === '0) passed++;
    else $error("FAIL exclusive t=%0t observed=%b expected=00", $time, pressed & released);
  endtask

  int dut_pc, mod_pc;

  initial begin
    reset = 1'b1;
    in    = '0;
    m_level = '0;
    for (int b = 0; b < SIZE; b++) begin m_run[b] = 0; m_rep[b] = 0; end

    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    check("reset_level", level, 2'b00);

    // press on bit 0, held 10 cycles; pressed lands after the 4th sample
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b01);
      if (i == 2) check("no_early_level", level, 2'b00);
      if (i == 3) check("press_lat", pressed, 2'b01);
      if (i == 4) check("press_1cyc", pressed, 2'b00);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 2'b00);
    check("released_low", level, 2'b00);

    // glitch of STAB-1 cycles is swallowed
    for (int i = 0; i < 3; i++) step(1'b0, 2'b01);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b00);
    check("glitch_level", level, 2'b00);

    // from HIGH: 0,0,1 then four 0s -> release only on 4th consecutive 0
    for (int i = 0; i < 6; i++) step(1'b0, 2'b01);
    step(1'b0, 2'b00); step(1'b0, 2'b00); step(1'b0, 2'b01);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'b00);
      if (i == 2) check("fall_hold", level, 2'b01);
      if (i == 3) check("fall_rel", released, 2'b01);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00);

    // both rise; bit 1 bounces at sample 2
    step(1'b0, 2'b11); step(1'b0, 2'b01);
    for (int i = 0; i < 7; i++) step(1'b0, 2'b11);
    for (int i = 0; i < 6; i++) step(1'b0, 2'b00);

    // reset mid-debounce (cnt=2) aborts, then a fresh press with input held
    step(1'b0, 2'b01); step(1'b0, 2'b01);
    step(1'b1, 2'b01);
    check("abort_level", level, 2'b00);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'b01);
      if (i == 3) check("repress", pressed, 2'b01);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 2'b00);

    // long hold: single pulse, or repeats every REP cycles with auto-repeat
    dut_pc = 0; mod_pc = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 2'b01);
      dut_pc += int'(pressed[0]);
      mod_pc += int'(m_pr[0]);
    end
    total++;
    assert (dut_pc === mod_pc) passed++;
    else $error("FAIL hold_pulses observed=%0d expected=%0d", dut_pc, mod_pc);
    for (int i = 0; i < 6; i++) step(1'b0, 2'b00);

    // random bouncing inputs with occasional reset
    begin
      logic [SIZE-1:0] v;
      v = '0;
      for (int i = 0; i < 600; i++) begin
        for (int b = 0; b < SIZE; b++)
          if ($urandom_range(0, 3) == 0) v[b] = ~v[b];
        step(($urandom_range(0, 63) == 0), v);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
